// File: rtl/can_bit_destuffer_pkg.sv
// Shared types and defaults for the CAN bit destuffer: state encoding,
// stuffing lengths and the Gray conversion used by the stuff counter.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DYN       = 2'd1,
    FIXED     = 2'd2,
    WAIT_IDLE = 2'd3
  } destuff_state_t;

  localparam int STUFF_LEN_DEF = 5;
  localparam int FIXED_LEN_DEF = 4;
  localparam int IDLE_BITS_DEF = 11;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/can_bit_destuffer_stuff_counter.sv
// Mod-8 count of dynamic stuff bits, presented Gray-coded with even parity
// for the FD stuff-count field.
module can_stuff_counter
  import can_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] gray,
  output logic       par
);

  logic [2:0] bin;
  logic [2:0] bin_nxt;

  always_comb begin
    bin_nxt = bin;
    if (clr)
      bin_nxt = 3'd0;
    else if (inc)
      bin_nxt = bin + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= 3'd0;
      gray <= 3'd0;
      par  <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin2gray(bin_nxt);
      par  <= ^bin2gray(bin_nxt);
    end
  end

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: SOF detection, dynamic and FD fixed stuff-bit flagging,
// stuff error reporting and bus-idle recovery.
//
//  state     | meaning
//  IDLE      | bus idle, waiting for a dominant SOF
//  DYN       | in frame, dynamic stuffing (run-length rule)
//  FIXED     | FD stuff-count/CRC field, fixed stuff bit every FIXED_LEN+1
//  WAIT_IDLE | after error, waiting for IDLE_BITS recessive samples
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int FIXED_LEN = FIXED_LEN_DEF,
  parameter int IDLE_BITS = IDLE_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp,
  input  logic       CAN_RX,
  input  logic       bs_on,
  input  logic       fd_crc,
  input  logic       error_flag,
  output logic       sof,
  output logic       bit_valid,
  output logic       rx_bit,
  output logic       is_stuff,
  output logic       stuff_err,
  output logic [2:0] stuff_cnt,
  output logic       stuff_par
);

  localparam int PW = $clog2(FIXED_LEN + 1);
  localparam int CW = $clog2(IDLE_BITS + 1);

  destuff_state_t state;
  logic [2:0]     run;
  logic           last;
  logic [PW-1:0]  pos;
  logic [CW-1:0]  rec;

  logic          same;
  logic          stuff_due;
  logic          rec_done;
  logic [CW-1:0] rec_nxt;
  logic [2:0]    run_inc;
  logic          cnt_clr;
  logic          cnt_inc;

  assign same      = (CAN_RX == last);
  assign stuff_due = bs_on && (run == 3'(STUFF_LEN));
  // This sample is the one that completes the recessive idle sequence.
  assign rec_done  = CAN_RX && (rec == CW'(IDLE_BITS - 1));
  assign rec_nxt   = !CAN_RX ? '0 : (rec == CW'(IDLE_BITS)) ? rec : rec + 1'b1;
  assign run_inc   = (run == 3'd7) ? run : run + 3'd1;

  assign cnt_clr = error_flag || (sp && state == IDLE && !CAN_RX);
  assign cnt_inc = sp && !error_flag && state == DYN && !fd_crc && stuff_due && !same;

  can_stuff_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .gray  (stuff_cnt),
    .par   (stuff_par)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run       <= 3'd0;
      last      <= 1'b1;
      pos       <= '0;
      rec       <= '0;
      sof       <= 1'b0;
      bit_valid <= 1'b0;
      rx_bit    <= 1'b0;
      is_stuff  <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      sof       <= 1'b0;
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;
      if (error_flag) begin
        state <= WAIT_IDLE;
        run   <= 3'd0;
        pos   <= '0;
        rec   <= '0;
      end else if (sp) begin
        case (state)
          IDLE: begin
            if (!CAN_RX) begin
              sof   <= 1'b1;
              run   <= 3'd1;
              last  <= 1'b0;
              rec   <= '0;
              state <= DYN;
            end
          end
          DYN: begin
            bit_valid <= 1'b1;
            rx_bit    <= CAN_RX;
            last      <= CAN_RX;
            rec       <= rec_nxt;
            if (fd_crc) begin
              // Entry bit into the fixed field is itself the first fixed stuff bit.
              is_stuff <= 1'b1;
              pos      <= PW'(1);
              if (same) begin
                stuff_err <= 1'b1;
                rec       <= '0;
                state     <= WAIT_IDLE;
              end else begin
                state <= FIXED;
              end
            end else if (stuff_due) begin
              is_stuff <= 1'b1;
              if (same) begin
                stuff_err <= 1'b1;
                rec       <= '0;
                state     <= WAIT_IDLE;
              end else begin
                run <= 3'd1;
              end
            end else begin
              is_stuff <= 1'b0;
              run      <= same ? run_inc : 3'd1;
              if (!bs_on && rec_done) begin
                rec   <= '0;
                last  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          FIXED: begin
            bit_valid <= 1'b1;
            rx_bit    <= CAN_RX;
            last      <= CAN_RX;
            rec       <= rec_nxt;
            if (!fd_crc) begin
              is_stuff <= 1'b0;
              run      <= 3'd1;
              pos      <= '0;
              state    <= DYN;
            end else if (pos == '0) begin
              is_stuff <= 1'b1;
              pos      <= PW'(1);
              if (same) begin
                stuff_err <= 1'b1;
                rec       <= '0;
                state     <= WAIT_IDLE;
              end
            end else begin
              is_stuff <= 1'b0;
              pos      <= (pos == PW'(FIXED_LEN)) ? '0 : pos + 1'b1;
            end
          end
          WAIT_IDLE: begin
            rec <= rec_nxt;
            if (rec_done) begin
              rec   <= '0;
              last  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
- Upstream neighbour of the CAN frame controller.
- Takes the sampled bus bit at each sample-point strobe, detects start-of-frame, and flags dynamic stuff bits (classic and FD arbitration/data) and fixed stuff bits (FD CRC field).
- Produces the is_stuff qualifier the frame controller uses to skip bits.
- Reports stuff errors and a Gray-coded stuff count with parity for FD CRC checking.

Parameters:
- STUFF_LEN, 5, equal consecutive bits that force a dynamic stuff bit.
- FIXED_LEN, 4, data bits between fixed stuff bits in FD CRC mode.
- IDLE_BITS, 11, consecutive recessive samples that declare bus idle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sp  in  1  one-cycle sample-point strobe (clk domain).
- CAN_RX  in  1  bus level at sample point (1 = recessive).
- bs_on  in  1  destuffing enable from frame controller (low from CRC delimiter on).
- fd_crc  in  1  level: FD frame in stuff-count/CRC field, fixed stuffing.
- error_flag  in  1  frame controller error; abort frame.
- sof  out  1  one-cycle pulse, SOF bit accepted.
- bit_valid  out  1  one-cycle pulse, rx_bit/is_stuff updated.
- rx_bit  out  1  last sampled bit.
- is_stuff  out  1  last sampled bit was a stuff bit (dynamic or fixed).
- stuff_err  out  1  one-cycle pulse, stuff rule violated.
- stuff_cnt  out  3  Gray-coded count (mod 8) of dynamic stuff bits in current frame.
- stuff_par  out  1  even parity over stuff_cnt.

Behaviour:
- Reset (and every output after reset): state IDLE, all outputs 0, run counter 0, last bit 1, recessive counter 0.
- Priority per clk edge: reset > error_flag > sp processing. All outputs are registered; bit_valid, sof and stuff_err assert the cycle after the sp edge.
- States:
  - IDLE: sp with CAN_RX=0 → sof=1, run=1, last=0, stuff_cnt=0, go DYN. No bit_valid for SOF. CAN_RX=1 ignored.
  - DYN, on sp:
    - bit_valid=1, rx_bit=CAN_RX.
    - If bs_on=1 and run==STUFF_LEN: the bit is a stuff bit, is_stuff=1.
    - If CAN_RX==last: stuff_err=1, go WAIT_IDLE.
    - Else stuff_cnt = Gray(binary+1), run=1, last=CAN_RX.
    - Otherwise is_stuff=0; run = run+1 if equal to last, else 1; last=CAN_RX.
    - With bs_on=0 run tracks but no stuff check is made.
    - fd_crc rising, sampled at sp, takes priority: go FIXED, and the current bit is treated as the first FIXED bit.
  - FIXED, on sp, position counter pos starts at 0:
    - pos==0: fixed stuff bit, is_stuff=1. It must equal ~last, else stuff_err, go WAIT_IDLE.
    - pos 1..FIXED_LEN: data, is_stuff=0.
    - pos wraps FIXED_LEN→0. last updated every bit.
    - Dynamic stuffing and stuff_cnt frozen.
    - fd_crc low at sp: go DYN with run=1 and the bit processed as DYN with no stuff check.
  - WAIT_IDLE: no bit_valid. Recessive counter counts consecutive CAN_RX=1 samples and resets on 0. Reaching IDLE_BITS → IDLE.
- Frame end from DYN: with bs_on=0, IDLE_BITS consecutive recessive samples → IDLE. bit_valid continues until then.
- error_flag in any state → WAIT_IDLE next cycle, counters cleared. A pending sp in the same cycle is dropped.
- stuff_err is a pulse; frame controller latches it.
- Saturation: run saturates at 7, recessive counter at IDLE_BITS.
- Stuff-bit count wraps mod 8 in Gray: 000,001,011,010,110,111,101,100,000.

Decomposition:
- Package can_pkg holds:
  - the destuffer state enum (IDLE, DYN, FIXED, WAIT_IDLE);
  - constants STUFF_LEN_DEF, FIXED_LEN_DEF, IDLE_BITS_DEF;
  - a bin2gray function.
- One natural sub-module: can_stuff_counter (3-bit binary counter with Gray output and parity, clear and increment inputs).

Test Plan:
- Idle then CAN_RX 0,0,0,0,0,1 with bs_on=1 → sof on first 0. Four bit_valid with is_stuff=0, then the 1 flagged is_stuff=1. stuff_cnt=001, stuff_par=1.
- Six consecutive 0 after SOF with bs_on=1 → stuff_err pulse on sixth bit, state WAIT_IDLE. 11 recessive samples → IDLE, next 0 gives sof.
- Data run 1,1,1,1,1 with bs_on=0 → no is_stuff, no stuff_err. Then 11 ones → IDLE.
- fd_crc=1 with last=1, bits 0,1,0,1,1,0 → is_stuff on first and sixth bit, no error. Repeat with the sixth bit equal to its predecessor → stuff_err.
- Eight dynamic stuff bits in one frame → stuff_cnt sequence 001,011,010,110,111,101,100,000. Parity matches each value.
- error_flag coincident with sp mid-frame → that bit gives no bit_valid. Next cycle WAIT_IDLE; synchronous reset mid-frame → all outputs 0 the next cycle.
